// File: rtl/scan_display_driver.sv
// Multiplexed 7-segment scanner: one digit per timed slot, dead-time blanking at slot start,
// per-digit enable mask, PWM brightness and a frame-done strobe on scan wrap.
module scan_display_driver #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned SLOT_CYCLES    = 1024,
   parameter int unsigned DEAD_CYCLES    = 16,
   parameter int unsigned BRIGHT_W       = 4,
   parameter bit          SEL_ACTIVE_LOW = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b0,
   localparam int unsigned IDX_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [DIGITS-1:0]     enable_mask,
   input  logic [BRIGHT_W-1:0]   brightness,
   input  logic [8*DIGITS-1:0]   seg_data,
   output logic [DIGITS-1:0]     select,
   output logic [7:0]            segments,
   output logic [IDX_W-1:0]      digit_index,
   output logic                  frame_done
);

   localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEAD_V    = CNT_W'(DEAD_CYCLES);
   localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StDead, StOn} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d, nxt;
   logic [7:0]          pat_q, pat_d;
   logic                frame_q, frame_d;
   logic [DIGITS-1:0]   select_q, select_d, sel_vec;
   logic [7:0]          segments_q, segments_d, seg_vec;
   logic [BRIGHT_W-1:0] pwm_pos;
   logic                wrap, lit;

   // First enabled digit after cur (wrapping), or the lowest enabled one when leaving idle.
   function automatic logic [IDX_W-1:0] pick_next(input logic [DIGITS-1:0] mask,
                                                  input logic [IDX_W-1:0]  cur,
                                                  input logic              from_idle);
      logic [IDX_W-1:0] res;
      logic             found;
      int               j;
      res   = cur;
      found = 1'b0;
      for (int k = 0; k < int'(DIGITS); k++) begin
         if (from_idle) j = k;
         else           j = (int'(cur) + k + 1) % int'(DIGITS);
         if (!found && mask[j]) begin
            res   = IDX_W'(j);
            found = 1'b1;
         end
      end
      return res;
   endfunction

   always_comb begin
      wrap    = (cnt_q == CNT_LAST);
      cnt_d   = wrap ? '0 : cnt_q + 1'b1;
      nxt     = pick_next(enable_mask, idx_q, state_q == StIdle);
      state_d = state_q;
      idx_d   = idx_q;
      pat_d   = pat_q;
      frame_d = 1'b0;
      if (wrap) begin
         if (|enable_mask) begin
            state_d = StDead;
            idx_d   = nxt;
            pat_d   = seg_data[8*nxt +: 8];
            frame_d = (state_q != StIdle) && (nxt <= idx_q);
         end else begin
            state_d = StIdle;
         end
      end else if (state_q == StDead && cnt_q == DEAD_LAST) begin
         state_d = StOn;
      end
   end

   // Outputs are computed from next-state so the registers line up with the counter.
   always_comb begin
      pwm_pos = BRIGHT_W'(cnt_d - DEAD_V);
      lit     = (&brightness) || (pwm_pos < brightness);
      sel_vec = '0;
      if (state_d == StOn) sel_vec[idx_d] = 1'b1;
      seg_vec    = (state_d == StOn && lit) ? pat_d : 8'h00;
      select_d   = SEL_ACTIVE_LOW ? ~sel_vec : sel_vec;
      segments_d = SEG_ACTIVE_LOW ? ~seg_vec : seg_vec;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         idx_q      <= '0;
         pat_q      <= '0;
         frame_q    <= 1'b0;
         select_q   <= {DIGITS{SEL_ACTIVE_LOW}};
         segments_q <= {8{SEG_ACTIVE_LOW}};
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         pat_q      <= pat_d;
         frame_q    <= frame_d;
         select_q   <= select_d;
         segments_q <= segments_d;
      end
   end

   assign select      = select_q;
   assign segments    = segments_q;
   assign digit_index = idx_q;
   assign frame_done  = frame_q;

endmodule

// File: tb/tb_scan_display_driver.sv
// Scoreboard bench for scan_display_driver: per-slot expectations are queued by the stimulus
// process and checked by a monitor at fixed points inside each slot.
module tb_scan_display_driver;

   localparam logic [31:0] D1 = 32'h065B4F66;
   localparam logic [31:0] D2 = 32'hA1B2C3D4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  enable_mask;
   logic [1:0]  brightness;
   logic [31:0] seg_data;
   logic [3:0]  select;
   logic [7:0]  segments;
   logic [1:0]  digit_index;
   logic        frame_done;

   scan_display_driver #(
      .DIGITS         (4),
      .SLOT_CYCLES    (32),
      .DEAD_CYCLES    (4),
      .BRIGHT_W       (2),
      .SEL_ACTIVE_LOW (1'b1),
      .SEG_ACTIVE_LOW (1'b0)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable_mask (enable_mask),
      .brightness  (brightness),
      .seg_data    (seg_data),
      .select      (select),
      .segments    (segments),
      .digit_index (digit_index),
      .frame_done  (frame_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  mask;
      logic [31:0] data;
      logic [1:0]  bright;
      logic        idle;
      logic [1:0]  dig;
      logic [7:0]  pat;
      logic        frame;
   } vec_t;

   typedef struct {
      logic       idle;
      logic [1:0] dig;
      logic [7:0] pat;
      logic [1:0] bright;
      logic       frame;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   bit   have = 1'b0;
   vec_t vecs[21];
   int   checks = 0;
   int   errors = 0;
   int   tc;

   // Bench timebase: position within the current 32-cycle slot.
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) tc <= 0;
      else          tc <= (tc == 31) ? 0 : tc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic vec_t mv(input logic [3:0] mask, input logic [31:0] data,
                               input logic [1:0] bright, input logic idle,
                               input logic [1:0] dig, input logic [7:0] pat,
                               input logic frame);
      vec_t v;
      v.mask = mask; v.data = data; v.bright = bright;
      v.idle = idle; v.dig = dig; v.pat = pat; v.frame = frame;
      return v;
   endfunction

   function automatic exp_t me(input logic idle, input logic [1:0] dig, input logic [7:0] pat,
                               input logic [1:0] bright, input logic frame);
      exp_t e;
      e.idle = idle; e.dig = dig; e.pat = pat; e.bright = bright; e.frame = frame;
      return e;
   endfunction

   function automatic logic [3:0] sel_of(input exp_t e);
      logic [3:0] one;
      one = 4'b0001;
      if (e.idle) return 4'hF;
      return ~(one << e.dig);
   endfunction

   function automatic logic [7:0] seg_of(input exp_t e, input int p);
      if (e.idle) return 8'h00;
      if (e.bright == 2'd3 || p < int'(e.bright)) return e.pat;
      return 8'h00;
   endfunction

   task automatic wait_tc(input int n);
      do @(negedge clock); while (tc != n);
   endtask

   always @(negedge clock) begin
      if (reset_n) begin
         if (tc == 0) begin
            if (exp_q.size() == 0) begin
               have = 1'b0;
               checks++;
               errors++;
               $display("FAIL scoreboard_underflow: got no entry expected one at %0t", $time);
            end else begin
               cur  = exp_q.pop_front();
               have = 1'b1;
            end
         end
         if (have) begin
            case (tc)
               0: begin
                  chk("frame_done_boundary", 32'(frame_done), 32'(cur.frame));
                  chk("select_boundary", 32'(select), 32'hF);
                  chk("segments_boundary", 32'(segments), 32'h0);
               end
               1: chk("frame_done_pulse_end", 32'(frame_done), 32'h0);
               3: begin
                  chk("select_dead", 32'(select), 32'hF);
                  chk("segments_dead", 32'(segments), 32'h0);
               end
               4: begin
                  chk("select_on", 32'(select), 32'(sel_of(cur)));
                  chk("digit_index", 32'(digit_index), 32'(cur.dig));
                  chk("segments_p0", 32'(segments), 32'(seg_of(cur, 0)));
               end
               5: chk("segments_p1", 32'(segments), 32'(seg_of(cur, 1)));
               7: chk("segments_p3", 32'(segments), 32'(seg_of(cur, 3)));
               30: begin
                  chk("select_late", 32'(select), 32'(sel_of(cur)));
                  chk("segments_p2_late", 32'(segments), 32'(seg_of(cur, 2)));
               end
               default: ;
            endcase
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // mask, data, bright | idle, digit, pattern, frame_done entering the slot
      vecs[0]  = mv(4'hF, D1, 2'd3, 1'b0, 2'd0, 8'h66, 1'b0);
      vecs[1]  = mv(4'hF, D1, 2'd3, 1'b0, 2'd1, 8'h4F, 1'b0);
      vecs[2]  = mv(4'hF, D1, 2'd3, 1'b0, 2'd2, 8'h5B, 1'b0);
      vecs[3]  = mv(4'hF, D1, 2'd3, 1'b0, 2'd3, 8'h06, 1'b0);
      vecs[4]  = mv(4'hF, D1, 2'd3, 1'b0, 2'd0, 8'h66, 1'b1);
      vecs[5]  = mv(4'hF, D1, 2'd3, 1'b0, 2'd1, 8'h4F, 1'b0);
      vecs[6]  = mv(4'h5, D1, 2'd2, 1'b0, 2'd2, 8'h5B, 1'b0);
      vecs[7]  = mv(4'h5, D1, 2'd2, 1'b0, 2'd0, 8'h66, 1'b1);
      vecs[8]  = mv(4'h5, D1, 2'd2, 1'b0, 2'd2, 8'h5B, 1'b0);
      vecs[9]  = mv(4'h5, D1, 2'd2, 1'b0, 2'd0, 8'h66, 1'b1);
      vecs[10] = mv(4'h8, D1, 2'd2, 1'b0, 2'd3, 8'h06, 1'b0);
      vecs[11] = mv(4'h8, D1, 2'd2, 1'b0, 2'd3, 8'h06, 1'b1);
      vecs[12] = mv(4'h8, D1, 2'd1, 1'b0, 2'd3, 8'h06, 1'b1);
      vecs[13] = mv(4'h8, D1, 2'd0, 1'b0, 2'd3, 8'h06, 1'b1);
      vecs[14] = mv(4'h8, D1, 2'd3, 1'b0, 2'd3, 8'h06, 1'b1);
      vecs[15] = mv(4'h8, D2, 2'd3, 1'b0, 2'd3, 8'hA1, 1'b1);
      vecs[16] = mv(4'h0, D2, 2'd3, 1'b1, 2'd3, 8'h00, 1'b0);
      vecs[17] = mv(4'h0, D2, 2'd3, 1'b1, 2'd3, 8'h00, 1'b0);
      vecs[18] = mv(4'h2, D2, 2'd3, 1'b0, 2'd1, 8'hC3, 1'b0);
      vecs[19] = mv(4'h6, D2, 2'd3, 1'b0, 2'd2, 8'hB2, 1'b0);
      vecs[20] = mv(4'h6, D2, 2'd3, 1'b0, 2'd1, 8'hC3, 1'b1);

      enable_mask = 4'hF;
      brightness  = 2'd3;
      seg_data    = D1;
      exp_q.push_back(me(1'b1, 2'd0, 8'h00, 2'd3, 1'b0));
      repeat (3) @(posedge clock);
      chk("reset_select", 32'(select), 32'hF);
      chk("reset_segments", 32'(segments), 32'h0);
      #1 reset_n = 1'b1;

      // Inputs for slot k+1 change mid-slot k; brightness is live, so it moves just before the edge.
      for (int k = 0; k < 21; k++) begin
         wait_tc(16);
         enable_mask = vecs[k].mask;
         seg_data    = vecs[k].data;
         exp_q.push_back(me(vecs[k].idle, vecs[k].dig, vecs[k].pat, vecs[k].bright,
                            vecs[k].frame));
         wait_tc(31);
         brightness = vecs[k].bright;
      end

      wait_tc(10);
      @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      chk("midslot_reset_select", 32'(select), 32'hF);
      chk("midslot_reset_segments", 32'(segments), 32'h0);
      chk("midslot_reset_index", 32'(digit_index), 32'h0);
      chk("midslot_reset_frame", 32'(frame_done), 32'h0);
      exp_q.push_back(me(1'b1, 2'd0, 8'h00, 2'd3, 1'b0));
      exp_q.push_back(me(1'b0, 2'd1, 8'hC3, 2'd3, 1'b0));
      exp_q.push_back(me(1'b0, 2'd2, 8'hB2, 2'd3, 1'b0));
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      repeat (3) wait_tc(31);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
